// File: rtl/game_controller.sv
// game_controller: top-level sequencer for the Space Invaders datapath.
//
// It drives the shared `mode` line (0 = hold datapath at initial positions,
// 1 = gameplay). It tracks lives, score and level, and it inserts frame-timed
// RESPAWN and LEVEL_CLEAR pauses between play phases.
//
// Optional feature: define GAME_CONTROLLER_HIGH_SCORE_EN to keep a high score
// register. The register is cleared only by restart_n. It is updated on entry
// to GAMEOVER with max(high_score, final score). When the macro is undefined,
// high_score is tied to 0.
//
// Ports:
//   clk           pixel clock
//   restart_n     asynchronous active-low reset
//   xCoord/yCoord VGA column/row counters; (0,0) marks the start of a frame
//   button_start  start button, synchronised, level-sensitive
//   spaceship_hit one-cycle pulse, the spaceship was struck
//   alien_killed  one-cycle pulse per alien killed by the player laser
//   saucer_killed one-cycle pulse, the saucer was killed
//   alien_alive   live mask of the aliens
//   aliens_landed level, an alien reached the spaceship row
//   mode          0 = datapath held, 1 = play
//   state         FSM state (IDLE=0 PLAY=1 RESPAWN=2 LEVEL_CLEAR=3 GAMEOVER=4)
//   lives, score, level, game_over, high_score  game status (all registered)
module game_controller #(
  parameter int START_LIVES    = 3,
  parameter int RESPAWN_FRAMES = 120,
  parameter int CLEAR_FRAMES   = 60,
  parameter int ALIEN_POINTS   = 10,
  parameter int SAUCER_POINTS  = 50,
  parameter int SCORE_MAX      = 9999
) (
  input  logic        clk,
  input  logic        restart_n,
  input  logic [9:0]  xCoord,
  input  logic [9:0]  yCoord,
  input  logic        button_start,
  input  logic        spaceship_hit,
  input  logic [2:0]  alien_killed,
  input  logic        saucer_killed,
  input  logic [2:0]  alien_alive,
  input  logic        aliens_landed,
  output logic        mode,
  output logic [2:0]  state,
  output logic [1:0]  lives,
  output logic [13:0] score,
  output logic [3:0]  level,
  output logic        game_over,
  output logic [13:0] high_score
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY     = 3'd1,
    S_RESPAWN  = 3'd2,
    S_CLEAR    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  localparam int MAX_FRAMES = (RESPAWN_FRAMES > CLEAR_FRAMES) ? RESPAWN_FRAMES : CLEAR_FRAMES;
  localparam int FRAME_W    = $clog2(MAX_FRAMES + 1);

  state_t             cur_state, next_state;
  logic [FRAME_W-1:0] frame_cnt, next_cnt;
  logic [1:0]         next_lives;
  logic [13:0]        next_score;
  logic [3:0]         next_level;
  logic               frame_tick;
  logic               btn_prev;
  logic               start_press;

  // Score increment is formed at 15 bits so the sum cannot wrap before the clamp.
  logic [1:0]  kill_count;
  logic [14:0] increment;
  logic [14:0] score_sum;
  logic [13:0] score_new;

  assign start_press = button_start & ~btn_prev;
  assign kill_count  = 2'(alien_killed[0]) + 2'(alien_killed[1]) + 2'(alien_killed[2]);
  assign increment   = 15'(kill_count) * 15'(ALIEN_POINTS)
                     + (saucer_killed ? 15'(SAUCER_POINTS) : 15'd0);
  assign score_sum   = {1'b0, score} + increment;
  assign score_new   = (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
  assign state       = cur_state;

  always_comb begin
    next_state = cur_state;
    next_lives = lives;
    next_score = score;
    next_level = level;
    next_cnt   = frame_cnt;
    case (cur_state)
      S_IDLE: begin
        if (start_press) begin
          next_state = S_PLAY;
          next_score = '0;
          next_lives = 2'(START_LIVES);
          next_level = 4'd1;
        end
      end
      S_PLAY: begin
        // Kills score even on the cycle that leaves PLAY.
        next_score = score_new;
        if (aliens_landed) begin
          next_state = S_GAMEOVER;
          next_lives = '0;
        end else if (spaceship_hit) begin
          if (lives <= 2'd1) begin
            next_state = S_GAMEOVER;
            next_lives = '0;
          end else begin
            next_state = S_RESPAWN;
            next_lives = lives - 2'd1;
            next_cnt   = '0;
          end
        end else if (alien_alive == 3'd0) begin
          next_state = S_CLEAR;
          next_cnt   = '0;
        end
      end
      S_RESPAWN: begin
        if (frame_tick) begin
          if (frame_cnt == FRAME_W'(RESPAWN_FRAMES - 1)) begin
            next_state = S_PLAY;
            next_cnt   = '0;
          end else begin
            next_cnt = frame_cnt + FRAME_W'(1);
          end
        end
      end
      S_CLEAR: begin
        if (frame_tick) begin
          if (frame_cnt == FRAME_W'(CLEAR_FRAMES - 1)) begin
            next_state = S_PLAY;
            next_cnt   = '0;
            next_level = (level == 4'd15) ? 4'd1 : level + 4'd1;
          end else begin
            next_cnt = frame_cnt + FRAME_W'(1);
          end
        end
      end
      S_GAMEOVER: begin
        if (start_press) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      cur_state  <= S_IDLE;
      frame_cnt  <= '0;
      lives      <= 2'(START_LIVES);
      score      <= '0;
      level      <= 4'd1;
      mode       <= 1'b0;
      game_over  <= 1'b0;
      frame_tick <= 1'b0;
      btn_prev   <= 1'b0;
    end else begin
      cur_state  <= next_state;
      frame_cnt  <= next_cnt;
      lives      <= next_lives;
      score      <= next_score;
      level      <= next_level;
      // mode and game_over decode the next state so they change on the same edge as state.
      mode       <= (next_state == S_PLAY);
      game_over  <= (next_state == S_GAMEOVER);
      frame_tick <= (xCoord == 10'd0) && (yCoord == 10'd0);
      btn_prev   <= button_start;
    end
  end

`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
  logic [13:0] high_q;

  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      high_q <= '0;
    end else if (next_state == S_GAMEOVER && cur_state != S_GAMEOVER && next_score > high_q) begin
      high_q <= next_score;
    end
  end

  assign high_score = high_q;
`else
  assign high_score = '0;
`endif

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;

  localparam int START_LIVES = 3;
  localparam int RESPAWN_N   = 120;
  localparam int CLEAR_N     = 60;

  logic        clk = 1'b0;
  logic        restart_n = 1'b0;
  logic [9:0]  xCoord, yCoord;
  logic        button_start = 1'b0;
  logic        spaceship_hit = 1'b0;
  logic [2:0]  alien_killed = 3'd0;
  logic        saucer_killed = 1'b0;
  logic [2:0]  alien_alive = 3'd7;
  logic        aliens_landed = 1'b0;
  logic        mode;
  logic [2:0]  st;
  logic [1:0]  lives;
  logic [13:0] score;
  logic [3:0]  level;
  logic        game_over;
  logic [13:0] high_score;

  int total = 0;
  int bad   = 0;

  game_controller dut (
    .clk(clk), .restart_n(restart_n), .xCoord(xCoord), .yCoord(yCoord),
    .button_start(button_start), .spaceship_hit(spaceship_hit),
    .alien_killed(alien_killed), .saucer_killed(saucer_killed),
    .alien_alive(alien_alive), .aliens_landed(aliens_landed),
    .mode(mode), .state(st), .lives(lives), .score(score), .level(level),
    .game_over(game_over), .high_score(high_score)
  );

  // ---------------- clock / pixel counter ----------------
  always #5 clk = ~clk;

  // A tiny 4x2 "screen": one frame every 8 clocks.
  int pix = 0;
  always @(posedge clk) begin
    #1;
    pix = (pix + 1) % 8;
  end
  assign xCoord = 10'(pix % 4);
  assign yCoord = 10'(pix / 4);

  // ---------------- reference model ----------------
  int m_state = 0, m_lives = START_LIVES, m_score = 0, m_level = 1;
  int m_frames = 0, m_hs = 0, m_respawn_ticks = 0;
  bit m_btn = 0, m_tick = 0;

  always @(posedge clk or negedge restart_n) begin
    int inc, prev;
    bit sp;
    if (!restart_n) begin
      m_state = 0; m_lives = START_LIVES; m_score = 0; m_level = 1;
      m_frames = 0; m_btn = 0; m_tick = 0; m_hs = 0;
    end else begin
      sp   = button_start && !m_btn;
      prev = m_state;
      case (m_state)
        0: if (sp) begin m_state = 1; m_score = 0; m_lives = START_LIVES; m_level = 1; end
        1: begin
          inc = $countones(alien_killed) * 10 + (saucer_killed ? 50 : 0);
          m_score = (m_score + inc > 9999) ? 9999 : m_score + inc;
          if (aliens_landed) begin m_state = 4; m_lives = 0; end
          else if (spaceship_hit) begin
            if (m_lives == 1) begin m_state = 4; m_lives = 0; end
            else begin m_lives--; m_state = 2; m_frames = 0; end
          end else if (alien_alive == 0) begin m_state = 3; m_frames = 0; end
        end
        2: if (m_tick) begin
          m_frames++; m_respawn_ticks++;
          if (m_frames == RESPAWN_N) m_state = 1;
        end
        3: if (m_tick) begin
          m_frames++;
          if (m_frames == CLEAR_N) begin m_state = 1; m_level = m_level % 15 + 1; end
        end
        4: if (sp) m_state = 0;
        default: m_state = 0;
      endcase
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
      if (m_state == 4 && prev != 4 && m_score > m_hs) m_hs = m_score;
`endif
      m_btn  = button_start;
      m_tick = (xCoord == 0) && (yCoord == 0);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("state", int'(st), m_state);
    check("mode", int'(mode), (m_state == 1) ? 1 : 0);
    check("lives", int'(lives), m_lives);
    check("score", int'(score), m_score);
    check("level", int'(level), m_level);
    check("game_over", int'(game_over), (m_state == 4) ? 1 : 0);
    check("high_score", int'(high_score), m_hs);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    button_start = 1'b1; cyc();
    button_start = 1'b0; cyc();
  endtask

  task automatic do_reset();
    restart_n = 1'b0; cyc(); cyc();
    restart_n = 1'b1; cyc();
  endtask

  task automatic pulse_kill(input logic [2:0] a, input logic s);
    alien_killed = a; saucer_killed = s; cyc();
    alien_killed = 3'd0; saucer_killed = 1'b0;
  endtask

  task automatic pulse_hit();
    spaceship_hit = 1'b1; cyc();
    spaceship_hit = 1'b0;
  endtask

  task automatic wait_play(input int budget);
    int n = 0;
    while (st != 3'd1 && n < budget) begin cyc(); n++; end
    check("reach_play", int'(st), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    cyc(); cyc();
    @(negedge clk);
    check("rst_state", int'(st), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_lives", int'(lives), 3);
    check("rst_score", int'(score), 0);
    check("rst_level", int'(level), 1);
    check("rst_game_over", int'(game_over), 0);
    restart_n = 1'b1; cyc();

    // Held start button: exactly one IDLE->PLAY transition.
    button_start = 1'b1;
    repeat (80) cyc();
    button_start = 1'b0; cyc();
    @(negedge clk);
    check("start_state", int'(st), 1);
    check("start_lives", int'(lives), 3);

    pulse_kill(3'b111, 1'b1);
    @(negedge clk);
    check("score_plus80", int'(score), 80);

    // Respawn: 120 frames with mode low, kills ignored.
    t0 = m_respawn_ticks;
    pulse_hit();
    @(negedge clk);
    check("hit_lives", int'(lives), 2);
    check("hit_mode", int'(mode), 0);
    repeat (3) pulse_kill(3'b111, 1'b1);
    @(negedge clk);
    check("respawn_score_held", int'(score), 80);
    wait_play(2000);
    check("respawn_ticks", m_respawn_ticks - t0, 120);
    @(negedge clk);
    check("respawn_mode_back", int'(mode), 1);

    // Level clears 1->2 ... ->15 -> wraps to 1.
    for (int lv = 2; lv <= 16; lv++) begin
      alien_alive = 3'd0; cyc();
      alien_alive = 3'd7;
      @(negedge clk);
      check("clear_state", int'(st), 3);
      wait_play(1200);
      @(negedge clk);
      check("clear_level", int'(level), (lv == 16) ? 1 : lv);
    end

    // Saturation: 80 + 123*80 + 70 = 9990, then clamp.
    repeat (123) begin alien_killed = 3'b111; saucer_killed = 1'b1; cyc(); end
    pulse_kill(3'b011, 1'b1);
    @(negedge clk);
    check("score_9990", int'(score), 9990);
    pulse_kill(3'b001, 1'b0);
    @(negedge clk);
    check("score_sat", int'(score), 9999);
    pulse_kill(3'b111, 1'b1);
    @(negedge clk);
    check("score_sat_hold", int'(score), 9999);

    // Lose remaining lives.
    pulse_hit();
    wait_play(2000);
    pulse_hit();
    @(negedge clk);
    check("go_state", int'(st), 4);
    check("go_lives", int'(lives), 0);
    check("go_flag", int'(game_over), 1);
    press_start();
    @(negedge clk);
    check("go_to_idle", int'(st), 0);
    check("idle_score_kept", int'(score), 9999);

    // Landed wins over a simultaneous hit.
    press_start();
    @(negedge clk);
    check("restart_score", int'(score), 0);
    aliens_landed = 1'b1; spaceship_hit = 1'b1; cyc();
    aliens_landed = 1'b0; spaceship_hit = 1'b0;
    @(negedge clk);
    check("landed_state", int'(st), 4);
    check("landed_lives", int'(lives), 0);
    press_start();

    // Randomized play checked by the model every cycle.
    press_start();
    repeat (4000) begin
      spaceship_hit = ($urandom_range(0, 199) == 0);
      alien_killed  = 3'($urandom_range(0, 7) & $urandom_range(0, 7) & $urandom_range(0, 7));
      saucer_killed = ($urandom_range(0, 29) == 0);
      alien_alive   = ($urandom_range(0, 299) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      aliens_landed = ($urandom_range(0, 1499) == 0);
      button_start  = ($urandom_range(0, 19) == 0);
      cyc();
    end
    spaceship_hit = 0; alien_killed = 0; saucer_killed = 0;
    alien_alive = 3'd7; aliens_landed = 0; button_start = 0;

    // Asynchronous reset in the middle of play.
    do_reset();
    press_start();
    pulse_kill(3'b001, 1'b0);
    cyc();
    restart_n = 1'b0;
    @(negedge clk);
    check("midrst_state", int'(st), 0);
    check("midrst_mode", int'(mode), 0);
    check("midrst_lives", int'(lives), 3);
    check("midrst_score", int'(score), 0);
    restart_n = 1'b1; cyc();

`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    press_start();
    pulse_kill(3'b111, 1'b1);
    pulse_kill(3'b111, 1'b0);
    pulse_kill(3'b001, 1'b0);
    aliens_landed = 1'b1; cyc(); aliens_landed = 1'b0;
    @(negedge clk);
    check("hs_game1", int'(high_score), 120);
    press_start();
    press_start();
    pulse_kill(3'b111, 1'b0);
    pulse_kill(3'b001, 1'b0);
    aliens_landed = 1'b1; cyc(); aliens_landed = 1'b0;
    @(negedge clk);
    check("hs_game2_score", int'(score), 40);
    check("hs_game2", int'(high_score), 120);
    do_reset();
    @(negedge clk);
    check("hs_reset", int'(high_score), 0);
`endif

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
